// File: rtl/mux_nway_arb.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Selects by external index (mode=0) or round-robin across requesters (mode=1).
module mux_nway_arb #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  localparam int unsigned IDX_W = SEL_W + 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [IDX_W-1:0] scan_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // Grant selection: fixed index or first requester at/after rr_ptr (mod NUM_CH).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (!mode) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (sel == SEL_W'(c) && in_valid[c]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(c);
        end
      end
    end else begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        scan_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
        if (scan_idx >= IDX_W'(NUM_CH)) scan_idx = scan_idx - IDX_W'(NUM_CH);
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (!grant_vld && scan_idx == IDX_W'(c) && in_valid[c]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(c);
          end
        end
      end
    end
  end

  // Handshake, data mux and next-state of the output stage.
  always_comb begin
    load_en     = !out_valid_q || out_ready;
    xfer        = rst_n && load_en && grant_vld;
    in_ready    = '0;
    grant_data  = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (grant_idx == SEL_W'(c)) begin
        grant_data  = in_data[c*WIDTH +: WIDTH];
        in_ready[c] = xfer;
      end
    end
    if (load_en) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = grant_data;
      out_ch_d   = grant_idx;
      if (mode) rr_ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/mux_nway_arb.md
Name: mux_nway_arb

Overview:
- Parametrised successor to the 4-way 16-bit combinational mux: an N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.
- Two selection modes: fixed select (external sel, as in the combinational mux) and round-robin arbitration across requesting channels.
- Registered single-entry output stage; sits between multiple producer blocks and one shared consumer in the datapath.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- WIDTH, 16, data width per channel in bits.
- SEL_W, 2, width of sel/out_ch; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  NUM_CH  per-channel request; bit c belongs to channel c.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel c at bits [c*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel accept, combinational; at most one bit high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. Any held word is dropped. in_ready=0 while rst_n=0.
- load_en = !out_valid | out_ready. Output accepts a new word when empty or draining in the same cycle, giving full throughput of 1 word/cycle.
- Grant, combinational:
  - mode=0: grant channel sel if sel<NUM_CH and in_valid[sel]=1. Otherwise no grant. sel>=NUM_CH never grants.
  - mode=1: grant the first c with in_valid[c]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH. No grant if in_valid=0.
- in_ready[g]=1 only for the granted channel and only when load_en=1. All other bits are 0.
- Transfer occurs on channel g when in_valid[g] & in_ready[g]. On the next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1. Latency is 1 cycle from accept to out_valid.
- If load_en=1 and there is no grant: out_valid<=0 (or stays 0). out_data and out_ch hold their previous values.
- If out_valid=1 and out_ready=0: out_data and out_ch are stable, all in_ready=0, and producers must hold.
- rr_ptr:
  - Updates only on an accepted transfer with mode=1: rr_ptr <= (g==NUM_CH-1) ? 0 : g+1. Wrap-around is required.
  - In mode=0, rr_ptr holds.
- Mode or sel changes take effect on the grant in the same cycle. They never alter a word already held in the output register.
- Simultaneous drain and load (out_valid=1, out_ready=1, new grant): the old word is consumed and the new word loads on the same edge. No bubble.
- Producers must not depend on in_ready before asserting in_valid. in_ready depends on in_valid, out_ready, mode and sel only, so there is no combinational loop.
- Widths: no arithmetic on data. rr_ptr and out_ch are SEL_W bits, and index math is mod NUM_CH, not mod 2**SEL_W.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release with mode=1 and out_ready=1 -> channel 0 is granted first.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data ch0..3 = 16'h0001/16'h0002/16'hABCD/16'h0004, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=16'hABCD, out_ch=2, and this repeats every cycle.
- Round-robin fairness: mode=1, all 4 valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1. Then in_valid=4'b1010 -> out_ch alternates 1,3,1,3, including the wrap from ch3 to ch1.
- Backpressure: out_ready=0 for 3 cycles with a word held (16'h1234, ch1) -> out_data/out_ch stable and in_ready=0. When out_ready=1, the word drains and the next grant loads on the same edge.
- Boundary: mode=0 with sel=3 and in_valid[3]=0 -> no grant and out_valid falls to 0. With NUM_CH=3 and sel=3 -> never grants. Switching mode 1->0 mid-stream -> the held word is unchanged and rr_ptr is frozen.
- Mid-operation reset: assert rst_n=0 while out_valid=1 with 16'hBEEF held -> next edge out_valid=0, out_data=0, rr_ptr=0.
